// File: rtl/perif_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM state encoding,
// requester indices and the counter-width helper.
package perif_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    // Requester 0 is the CPU Mem_IO side, requester 1 is debug/DMA.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Number of bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value - 1;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/perif_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin selector: on a tie the requester that was not
// granted last wins; a lone requester always wins.
module rr_arbiter2
    import perif_bus_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_grant
);

    // Combinational winner selection
    always_comb begin
        o_valid = |i_req;
        o_grant = REQ_CPU;
        case (i_req)
            2'b01:   o_grant = REQ_CPU;
            2'b10:   o_grant = REQ_DBG;
            2'b11:   o_grant = ~i_last;
            default: o_grant = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/perif_bus_arbiter.sv
// Peripheral bus arbiter: grants one of two requesters round-robin and runs
// a fixed SETUP / ACCESS(WAIT_CYCLES) / DONE bus cycle for the winner.
// The tri-state buffer itself lives at the top level; this block only
// provides o_data_out and its enable.
module perif_bus_arbiter
    import perif_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [1:0]            i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic [1:0]            o_done,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_addr_bus,
    output logic                  o_cs_perif,
    output logic                  o_w_r,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_oe,
    input  logic [DATA_WIDTH-1:0] i_data_in
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("perif_bus_arbiter: WAIT_CYCLES must be in 1..15");
    end

    localparam int CNT_W = clogb2(WAIT_CYCLES + 1);

    state_e                  state_q;
    state_e                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    cnt_last;
    logic                    win_q;
    logic                    last_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    arb_valid;
    logic                    arb_win;

    rr_arbiter2 u_rr (
        .i_req   (i_req),
        .i_last  (last_q),
        .o_valid (arb_valid),
        .o_grant (arb_win)
    );

    // The counter loads the full wait count and stops at one, so "one" marks
    // the final ACCESS cycle for every legal WAIT_CYCLES.
    assign cnt_last = (cnt_q == CNT_W'(1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's command on leaving IDLE so later input changes are ignored
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            win_q   <= REQ_CPU;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (state_q == ST_IDLE && arb_valid) begin
            win_q   <= arb_win;
            addr_q  <= arb_win ? i_addr1 : i_addr0;
            wr_q    <= i_wr[arb_win];
            wdata_q <= arb_win ? i_wdata1 : i_wdata0;
        end
    end

    // ACCESS cycle counter: loads in SETUP, counts down without wrapping
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            cnt_q <= CNT_W'(WAIT_CYCLES);
        end else if (state_q == ST_ACCESS && !cnt_last) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Read data capture on the last ACCESS cycle; held until the next read
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rdata_q <= '0;
        end else if (state_q == ST_ACCESS && cnt_last && !wr_q) begin
            rdata_q <= i_data_in;
        end
    end

    // Last-granted pointer, updated when a transaction completes
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_q <= REQ_DBG;
        end else if (state_q == ST_DONE) begin
            last_q <= win_q;
        end
    end

    // Bus and completion outputs decoded from the current state
    always_comb begin
        o_cs_perif = 1'b0;
        o_w_r      = 1'b0;
        o_data_oe  = 1'b0;
        o_data_out = '0;
        o_done     = 2'b00;
        case (state_q)
            ST_SETUP, ST_ACCESS: begin
                o_cs_perif = 1'b1;
                o_w_r      = wr_q;
                o_data_oe  = wr_q;
                o_data_out = wr_q ? wdata_q : '0;
            end
            ST_DONE: begin
                o_done[win_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_addr_bus = addr_q;
    assign o_rdata    = rdata_q;

endmodule

// File: tb/tb_perif_bus_arbiter.sv
// Self-checking bench for perif_bus_arbiter: directed scenarios plus a
// randomized phase checked against a transaction-level reference model.
module tb_perif_bus_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;

    // Main instance (WAIT_CYCLES = 2)
    logic [1:0]    i_req = 2'b00;
    logic [AW-1:0] i_addr0 = '0, i_addr1 = '0;
    logic [1:0]    i_wr = 2'b00;
    logic [DW-1:0] i_wdata0 = '0, i_wdata1 = '0, i_data_in = '0;
    logic [1:0]    o_done;
    logic [DW-1:0] o_rdata, o_data_out;
    logic [AW-1:0] o_addr_bus;
    logic          o_cs_perif, o_w_r, o_data_oe;

    // Second instance (WAIT_CYCLES = 1)
    logic [1:0]    b_req = 2'b00;
    logic [AW-1:0] b_addr0 = '0, b_addr1 = '0;
    logic [1:0]    b_wr = 2'b00;
    logic [DW-1:0] b_wdata0 = '0, b_wdata1 = '0, b_data_in = '0;
    logic [1:0]    b_done;
    logic [DW-1:0] b_rdata, b_data_out;
    logic [AW-1:0] b_addr_bus;
    logic          b_cs_perif, b_w_r, b_data_oe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    perif_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_addr0(i_addr0), .i_addr1(i_addr1),
        .i_wr(i_wr), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .o_done(o_done),
        .o_rdata(o_rdata), .o_addr_bus(o_addr_bus), .o_cs_perif(o_cs_perif), .o_w_r(o_w_r),
        .o_data_out(o_data_out), .o_data_oe(o_data_oe), .i_data_in(i_data_in)
    );

    perif_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut_w1 (
        .i_clk(clk), .i_rst(i_rst), .i_req(b_req), .i_addr0(b_addr0), .i_addr1(b_addr1),
        .i_wr(b_wr), .i_wdata0(b_wdata0), .i_wdata1(b_wdata1), .o_done(b_done),
        .o_rdata(b_rdata), .o_addr_bus(b_addr_bus), .o_cs_perif(b_cs_perif), .o_w_r(b_w_r),
        .o_data_out(b_data_out), .o_data_oe(b_data_oe), .i_data_in(b_data_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- Transaction-level reference model ----------------
    // A granted transaction started at period S occupies S..S+2+WC:
    // offset 1..1+WC is the chip-select window, 2+WC is the done pulse,
    // read data is taken from the bus at offset 1+WC.
    bit            m_active = 1'b0;
    int            m_start  = 0;
    int            m_cyc    = 0;
    logic          m_win    = 1'b0;
    logic          m_last   = 1'b1;
    logic          m_wr     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [DW-1:0] m_rdata  = '0;

    task automatic model_edge();
        int k;
        if (!i_rst) begin
            m_active = 1'b0;
            m_last   = 1'b1;
            m_rdata  = '0;
        end else if (m_active) begin
            k = m_cyc - m_start;
            if (k == 1 + WC && !m_wr) m_rdata = i_data_in;
            if (k == 2 + WC) begin
                m_last   = m_win;
                m_active = 1'b0;
            end
        end else if (i_req != 2'b00) begin
            m_active = 1'b1;
            m_start  = m_cyc;
            m_win    = (i_req == 2'b11) ? ~m_last : i_req[1];
            m_addr   = m_win ? i_addr1 : i_addr0;
            m_wr     = i_wr[m_win];
            m_wdata  = m_win ? i_wdata1 : i_wdata0;
        end
        m_cyc++;
    endtask

    task automatic model_check();
        int         k;
        bit         cs;
        logic [1:0] done;
        k    = m_cyc - m_start;
        cs   = m_active && k >= 1 && k <= 1 + WC;
        done = (m_active && k == 2 + WC) ? (2'b01 << m_win) : 2'b00;
        chk("m_cs", 32'(o_cs_perif), 32'(cs));
        chk("m_oe", 32'(o_data_oe), 32'(cs && m_wr));
        chk("m_done", 32'(o_done), 32'(done));
        chk("m_rdata", 32'(o_rdata), 32'(m_rdata));
        if (cs) begin
            chk("m_addr", 32'(o_addr_bus), 32'(m_addr));
            chk("m_w_r", 32'(o_w_r), 32'(m_wr));
            if (m_wr) chk("m_wdata", 32'(o_data_out), 32'(m_wdata));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            model_check();
        end
    end

    // ---------------- Directed helpers ----------------
    task automatic single_op(input int r, input logic [AW-1:0] a, input logic w,
                             input logic [DW-1:0] wd, input logic [DW-1:0] bus,
                             output int done_at, output int cs_cnt, output int oe_cnt,
                             output logic [1:0] dv, output logic [DW-1:0] rd);
        @(negedge clk);
        i_data_in = bus;
        if (r == 0) begin i_addr0 = a; i_wdata0 = wd; end
        else        begin i_addr1 = a; i_wdata1 = wd; end
        i_wr[r]  = w;
        i_req[r] = 1'b1;
        done_at = -1; cs_cnt = 0; oe_cnt = 0; dv = 2'b00; rd = '0;
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            @(negedge clk);
            cs_cnt += int'(o_cs_perif);
            oe_cnt += int'(o_data_oe);
            if (o_done != 2'b00) begin
                done_at  = c;
                dv       = o_done;
                rd       = o_rdata;
                i_req[r] = 1'b0;
            end
        end
        if (done_at < 0) begin
            i_req[r] = 1'b0;
            chk("op_timeout", 32'd0, 32'd1);
        end
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        int            done_at, cs_cnt, oe_cnt;
        logic [1:0]    dv;
        logic [DW-1:0] rd;
        int            got_at [4];
        logic [1:0]    got_dv [4];
        int            n_got;

        #1 i_rst = 1'b0;
        #2;
        chk("rst_cs", 32'(o_cs_perif), 32'd0);
        chk("rst_oe", 32'(o_data_oe), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_w_r", 32'(o_w_r), 32'd0);
        chk("rst_addr", 32'(o_addr_bus), 32'd0);
        chk("rst_dout", 32'(o_data_out), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        repeat (3) @(negedge clk);
        i_rst = 1'b1;

        // Single write from requester 0
        single_op(0, 10'h005, 1'b1, 16'hBEEF, 16'h0000, done_at, cs_cnt, oe_cnt, dv, rd);
        chk("wr_done_at", 32'(done_at), 32'd4);
        chk("wr_cs_cycles", 32'(cs_cnt), 32'd3);
        chk("wr_oe_cycles", 32'(oe_cnt), 32'd3);
        chk("wr_done_bits", 32'(dv), 32'd1);

        // Single read from requester 1
        single_op(1, 10'h3FF, 1'b0, 16'h0000, 16'h1234, done_at, cs_cnt, oe_cnt, dv, rd);
        chk("rd_done_at", 32'(done_at), 32'd4);
        chk("rd_oe_cycles", 32'(oe_cnt), 32'd0);
        chk("rd_done_bits", 32'(dv), 32'd2);
        chk("rd_data", 32'(rd), 32'h1234);

        // Simultaneous requests: alternating grants, 5-cycle spacing
        @(negedge clk);
        i_addr0 = 10'h0A0; i_addr1 = 10'h0A1; i_wr = 2'b00; i_data_in = 16'h5555;
        i_req = 2'b11;
        n_got = 0;
        for (int c = 1; c <= 40 && n_got < 4; c++) begin
            @(negedge clk);
            if (o_done != 2'b00) begin
                got_at[n_got] = c;
                got_dv[n_got] = o_done;
                n_got++;
                if (n_got == 4) i_req = 2'b00;
            end
        end
        i_req = 2'b00;
        chk("rr_count", 32'(n_got), 32'd4);
        for (int i = 0; i < n_got; i++) begin
            chk("rr_grant", 32'(got_dv[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) chk("rr_spacing", 32'(got_at[i] - got_at[i-1]), 32'(3 + WC));
        end

        // Address change during ACCESS must not reach the bus
        @(negedge clk);
        i_addr0 = 10'h001; i_wdata0 = 16'h1111; i_wr[0] = 1'b1; i_req[0] = 1'b1;
        done_at = -1;
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 2) begin i_addr0 = 10'h002; i_wdata0 = 16'h2222; end
            if (o_cs_perif) chk("hold_addr", 32'(o_addr_bus), 32'h001);
            if (o_done != 2'b00) begin done_at = c; i_req[0] = 1'b0; end
        end
        i_req[0] = 1'b0;
        chk("hold_done_at", 32'(done_at), 32'd4);

        // Reset during ACCESS: immediate bus release, no done, requester 0 wins next
        @(negedge clk);
        i_addr0 = 10'h0CC; i_wdata0 = 16'hCAFE; i_wr[0] = 1'b1; i_req[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_cs", 32'(o_cs_perif), 32'd1);
        #2 i_rst = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(o_cs_perif), 32'd0);
        chk("mid_rst_oe", 32'(o_data_oe), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        i_addr1 = 10'h0DD; i_wr = 2'b00; i_req = 2'b11;
        @(negedge clk);
        i_rst = 1'b1;
        done_at = -1; dv = 2'b00;
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            @(negedge clk);
            if (o_done != 2'b00) begin done_at = c; dv = o_done; i_req = 2'b00; end
        end
        i_req = 2'b00;
        chk("post_rst_winner", 32'(dv), 32'd1);
        chk("post_rst_done_at", 32'(done_at), 32'd4);

        // WAIT_CYCLES = 1 instance: read completes at N+3, data taken in ACCESS
        @(negedge clk);
        b_addr0 = 10'h155; b_wr = 2'b00; b_data_in = 16'hA5A5; b_req = 2'b01;
        done_at = -1; cs_cnt = 0;
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            @(negedge clk);
            cs_cnt += int'(b_cs_perif);
            if (c == 2) b_data_in = 16'h5A5A;
            if (b_done != 2'b00) begin
                done_at = c;
                chk("w1_done_bits", 32'(b_done), 32'd1);
                chk("w1_rdata", 32'(b_rdata), 32'h5A5A);
                b_req = 2'b00;
                b_data_in = 16'hFFFF;
            end
        end
        b_req = 2'b00;
        chk("w1_done_at", 32'(done_at), 32'd3);
        chk("w1_cs_cycles", 32'(cs_cnt), 32'd2);
        repeat (2) @(negedge clk);
        chk("w1_rdata_hold", 32'(b_rdata), 32'h5A5A);

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            i_data_in = DW'($urandom);
            for (int r = 0; r < 2; r++) begin
                if (o_done[r]) begin
                    i_req[r] = 1'b0;
                end else if (!i_req[r]) begin
                    if ($urandom_range(2) == 0) begin
                        if (r == 0) begin i_addr0 = AW'($urandom); i_wdata0 = DW'($urandom); end
                        else        begin i_addr1 = AW'($urandom); i_wdata1 = DW'($urandom); end
                        i_wr[r]  = 1'($urandom);
                        i_req[r] = 1'b1;
                    end
                end else begin
                    if ($urandom_range(15) == 0) begin
                        if (r == 0) begin i_addr0 = AW'($urandom); i_wdata0 = DW'($urandom); end
                        else        begin i_addr1 = AW'($urandom); i_wdata1 = DW'($urandom); end
                        i_wr[r] = 1'($urandom);
                    end
                    if ($urandom_range(63) == 0) i_req[r] = 1'b0;
                end
            end
        end
        i_req = 2'b00;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
